// File: rtl/apple_bridge_seq.sv
// rtl/apple_bridge_seq.sv - multi-requester sequencer for a strobed latch bridge
//
// Ports:
//   clk_logic, device_reset_n      clock, async active-low reset
//   req_valid_i/ready_o/write_i    per-channel request handshake and direction
//   req_sel_i, req_data_i          per-channel packed target select and write data
//   rsp_valid_o/id_o/data_o        one-cycle read completion, data held until next read
//   bridge_sel_o, bridge_rd_n_o,   bridge control: select, read strobe (low in IDLE),
//   bridge_wr_n_o, bridge_d_o,     write strobe, write data, data output enable
//   bridge_d_oe_o, bridge_d_i      and bridge readback
//   idle_data_o                    bridge readback sampled while settled in IDLE
//   busy_o                         high whenever a transaction is in flight
module apple_bridge_seq #(
  parameter int NUM_REQ       = 4,
  parameter int SEL_WIDTH     = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1,
  parameter int HOLD_CYCLES   = 1,
  parameter int IDLE_SEL      = 0,
  parameter int RR_MODE       = 0,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_logic,
  input  logic                          device_reset_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]  req_sel_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic                          rsp_valid_o,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic [SEL_WIDTH-1:0]          bridge_sel_o,
  output logic                          bridge_rd_n_o,
  output logic                          bridge_wr_n_o,
  output logic [DATA_WIDTH-1:0]         bridge_d_o,
  output logic                          bridge_d_oe_o,
  input  logic [DATA_WIDTH-1:0]         bridge_d_i,
  output logic [DATA_WIDTH-1:0]         idle_data_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  localparam logic [SEL_WIDTH-1:0] IDLE_SEL_V = SEL_WIDTH'(IDLE_SEL);

  state_t                  state, next_state;
  logic [3:0]              cnt, next_cnt;
  logic                    phase_last;

  logic                    lat_write;
  logic [SEL_WIDTH-1:0]    lat_sel;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic [ID_W-1:0]         lat_id;
  logic [ID_W-1:0]         last_grant;
  logic                    prev_idle;
  logic                    capture;

  logic [ID_W-1:0]         win_id;
  logic                    win_found;
  logic                    grant;

  // Winner search; round-robin starts one past the last granted channel.
  always_comb begin
    int idx;
    win_id    = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (RR_MODE != 0) idx = (int'(last_grant) + 1 + i) % NUM_REQ;
      else              idx = i;
      if (!win_found && req_valid_i[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign grant       = (state == S_IDLE) && win_found;
  // Gated with reset so nothing is accepted while the block is held in reset.
  assign req_ready_o = (grant && device_reset_n) ? (NUM_REQ'(1) << win_id) : '0;
  assign busy_o      = (state != S_IDLE);
  assign capture     = (state == S_STROBE) && !lat_write && phase_last;

  always_comb begin
    phase_last = 1'b0;
    case (state)
      S_SETUP:  phase_last = (cnt == 4'(SETUP_CYCLES - 1));
      S_STROBE: phase_last = (cnt == 4'(STROBE_CYCLES - 1));
      S_HOLD:   phase_last = (cnt == 4'(HOLD_CYCLES - 1));
      default:  phase_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state    = state;
    next_cnt      = cnt;
    bridge_sel_o  = IDLE_SEL_V;
    bridge_rd_n_o = 1'b1;
    bridge_wr_n_o = 1'b1;
    bridge_d_oe_o = 1'b0;
    case (state)
      S_IDLE: begin
        // The idle port is read continuously, but rd_n stays high in reset.
        bridge_rd_n_o = !device_reset_n;
        next_cnt      = '0;
        if (win_found) next_state = S_SETUP;
      end
      S_SETUP: begin
        bridge_sel_o  = lat_sel;
        bridge_d_oe_o = lat_write;
        bridge_rd_n_o = lat_write;
        if (phase_last) begin
          next_state = S_STROBE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end
      S_STROBE: begin
        bridge_sel_o  = lat_sel;
        bridge_d_oe_o = lat_write;
        bridge_rd_n_o = lat_write;
        bridge_wr_n_o = !lat_write;
        if (phase_last) begin
          next_state = S_HOLD;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end
      S_HOLD: begin
        // Writes keep select and data driven; reads release to the idle port.
        bridge_sel_o  = lat_write ? lat_sel : IDLE_SEL_V;
        bridge_d_oe_o = lat_write;
        if (phase_last) begin
          next_state = S_IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end
      default: begin
        next_state = S_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign bridge_d_o = lat_data;

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      lat_write   <= 1'b0;
      lat_sel     <= IDLE_SEL_V;
      lat_data    <= '0;
      lat_id      <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      prev_idle   <= 1'b0;
      idle_data_o <= '0;
    end else begin
      if (grant) begin
        lat_write  <= req_write_i[win_id];
        lat_sel    <= req_sel_i[win_id*SEL_WIDTH +: SEL_WIDTH];
        lat_data   <= req_data_i[win_id*DATA_WIDTH +: DATA_WIDTH];
        lat_id     <= win_id;
        last_grant <= win_id;
      end
      rsp_valid_o <= capture;
      rsp_id_o    <= capture ? lat_id : '0;
      if (capture) rsp_data_o <= bridge_d_i;
      // One IDLE cycle of settle before the idle port sample is trusted.
      prev_idle <= (state == S_IDLE);
      if ((state == S_IDLE) && prev_idle) idle_data_o <= bridge_d_i;
    end
  end

endmodule
